triggerrec_edge_capture: RTL and testbench

TRIGGERREC_EDGE_CAPTURE -- requirements
Module: triggerrec_edge_capture

---
 rtl/triggerrec_edge_capture_pkg.sv | 31 +++
 rtl/triggerrec_skid2.sv | 87 ++++++++
 rtl/triggerrec_edge_capture.sv | 101 ++++++++++
 tb/tb_triggerrec_edge_capture.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/triggerrec_edge_capture_pkg.sv
// Shared definitions for the trigger-recorder edge capture block:
// event word geometry, default channel/timestamp split, overflow
// counter width and the state encoding of the two-entry output buffer.
package triggerrec_edge_capture_pkg;

  // An event word is always one 64-bit FIFO beat: snapshot over timestamp.
  localparam int EV_WIDTH      = 64;
  localparam int DEF_IO_LENGTH = 16;
  localparam int DEF_TS_WIDTH  = 48;

  // Dropped-event counter saturates rather than wrapping so software
  // can tell "many" from "a few".
  localparam int                   OVF_WIDTH = 16;
  localparam logic [OVF_WIDTH-1:0] OVF_MAX   = '1;

  // Fill level of the output buffer; the encoding doubles as the count.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_t;

  // Saturating increment used by the overflow counter.
  function automatic logic [OVF_WIDTH-1:0] satInc(input logic [OVF_WIDTH-1:0] value);
    if (value == OVF_MAX) begin
      return value;
    end
    return value + OVF_WIDTH'(1);
  endfunction

endpackage

// File: rtl/triggerrec_skid2.sv
// Two-entry output buffer for event words. The oldest entry is held in a
// dedicated output register so the consumer sees registered valid/data;
// the second entry waits behind it. A push that finds both slots full and
// no pop in the same cycle is refused and flagged on o_drop.
module triggerrec_skid2
  import triggerrec_edge_capture_pkg::*;
#(
  parameter int WIDTH = EV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_drop
);

  buf_state_t       r_state;
  logic             r_valid;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic             w_pop;

  // A word leaves only when it is actually being presented.
  assign w_pop  = r_valid & i_ready;

  // Refusal happens only when both slots stay occupied through this cycle.
  assign o_drop = i_push & (r_state == BUF_TWO) & ~w_pop;

  // Fill-level state machine; head/tail move only on accepted push or pop,
  // so the head is stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= BUF_EMPTY;
      r_valid <= 1'b0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case (r_state)
        BUF_EMPTY: begin
          if (i_push) begin
            r_head  <= i_data;
            r_valid <= 1'b1;
            r_state <= BUF_ONE;
          end
        end
        BUF_ONE: begin
          case ({i_push, w_pop})
            2'b10: begin
              r_tail  <= i_data;
              r_state <= BUF_TWO;
            end
            2'b01: begin
              r_valid <= 1'b0;
              r_state <= BUF_EMPTY;
            end
            2'b11: begin
              r_head <= i_data;
            end
            default: begin
            end
          endcase
        end
        BUF_TWO: begin
          if (w_pop) begin
            r_head <= r_tail;
            if (i_push) begin
              r_tail <= i_data;
            end else begin
              r_state <= BUF_ONE;
            end
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= BUF_EMPTY;
        end
      endcase
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_head;

endmodule

// File: rtl/triggerrec_edge_capture.sv
// Edge-triggered event recorder. Pin levels are synchronised, compared
// with their previous value against per-channel rise/fall masks, and any
// qualifying change produces one event word {snapshot, timestamp} that is
// queued in a two-entry buffer. Events that find the buffer full are
// counted in a saturating overflow counter.
module triggerrec_edge_capture
  import triggerrec_edge_capture_pkg::*;
#(
  parameter int IO_LENGTH = DEF_IO_LENGTH,
  parameter int TS_WIDTH  = DEF_TS_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [IO_LENGTH-1:0] io_in,
  input  logic [IO_LENGTH-1:0] rise_mask,
  input  logic [IO_LENGTH-1:0] fall_mask,
  input  logic                 ts_load,
  input  logic [TS_WIDTH-1:0]  ts_load_val,
  input  logic                 ovf_clr,
  output logic                 ev_valid,
  output logic [EV_WIDTH-1:0]  ev_data,
  input  logic                 ev_ready,
  output logic [TS_WIDTH-1:0]  timestamp,
  output logic [OVF_WIDTH-1:0] ovf_cnt
);

  localparam logic [TS_WIDTH-1:0] TS_ONE = TS_WIDTH'(1);

  logic [IO_LENGTH-1:0] r_s1;
  logic [IO_LENGTH-1:0] r_s2;
  logic [IO_LENGTH-1:0] r_prev;
  logic [TS_WIDTH-1:0]  r_ts;
  logic [OVF_WIDTH-1:0] r_ovf;

  logic [IO_LENGTH-1:0] w_edges;
  logic                 w_hit;
  logic [EV_WIDTH-1:0]  w_ev_word;
  logic                 w_drop;

  // Two-flop synchroniser plus history; history follows s2 even while
  // disabled so re-enabling never reports changes made in the meantime.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_prev <= '0;
    end else begin
      r_s1   <= io_in;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  // Any masked rising or falling channel qualifies; all channels that
  // change together collapse into a single event.
  assign w_edges   = (r_s2 & ~r_prev & rise_mask) | (~r_s2 & r_prev & fall_mask);
  assign w_hit     = enable & (|w_edges);
  assign w_ev_word = {r_s2, r_ts};

  // Free-running timestamp gated by enable; a load wins over counting and
  // is honoured even while disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ts <= '0;
    end else if (ts_load) begin
      r_ts <= ts_load_val;
    end else if (enable) begin
      r_ts <= r_ts + TS_ONE;
    end
  end

  // Dropped-event counter; clear beats a simultaneous drop, and reset
  // discards buffered words without counting them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= '0;
    end else if (ovf_clr) begin
      r_ovf <= '0;
    end else if (w_drop) begin
      r_ovf <= satInc(r_ovf);
    end
  end

  triggerrec_skid2 #(
    .WIDTH (EV_WIDTH)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_hit),
    .i_data  (w_ev_word),
    .i_ready (ev_ready),
    .o_valid (ev_valid),
    .o_data  (ev_data),
    .o_drop  (w_drop)
  );

  assign timestamp = r_ts;
  assign ovf_cnt   = r_ovf;

endmodule

// File: tb/tb_triggerrec_edge_capture.sv
// Self-checking bench for triggerrec_edge_capture: a behavioural reference
// model feeds a scoreboard queue of expected event words, a table of
// single-edge vectors covers the edge/mask combinations, and directed
// sequences cover buffering, overflow, timestamp wrap and reset corners.
module tb_triggerrec_edge_capture;

  typedef struct {
    logic [15:0] fromLvl;
    logic [15:0] toLvl;
    logic [15:0] rise;
    logic [15:0] fall;
    logic        expEv;
    logic [15:0] expSnap;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] io_in;
  logic [15:0] rise_mask;
  logic [15:0] fall_mask;
  logic        ts_load;
  logic [47:0] ts_load_val;
  logic        ovf_clr;
  logic        ev_valid;
  logic [63:0] ev_data;
  logic        ev_ready;
  logic [47:0] timestamp;
  logic [15:0] ovf_cnt;

  int          nChecks = 0;
  int          nErrors = 0;
  logic        chkEn   = 1'b1;

  logic [15:0] mS1, mS2, mPrev;
  logic [47:0] mTs;
  logic [15:0] mOvf;
  logic [63:0] sb[$];

  vec_t        vecs[8];
  logic [47:0] expTs;
  logic [47:0] tsExp[3];

  triggerrec_edge_capture dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .io_in       (io_in),
    .rise_mask   (rise_mask),
    .fall_mask   (fall_mask),
    .ts_load     (ts_load),
    .ts_load_val (ts_load_val),
    .ovf_clr     (ovf_clr),
    .ev_valid    (ev_valid),
    .ev_data     (ev_data),
    .ev_ready    (ev_ready),
    .timestamp   (timestamp),
    .ovf_cnt     (ovf_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Hard stop in case something upstream never returns.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] lvl, input logic [15:0] rise, input logic [15:0] fall);
    io_in     = lvl;
    rise_mask = rise;
    fall_mask = fall;
  endtask

  // Advance the reference model across one clock edge using the inputs
  // currently applied, then compare DUT outputs 1 ns after the edge.
  task automatic tick();
    logic        hit;
    logic        drop;
    logic [63:0] word;
    if (reset) begin
      mS1 = '0; mS2 = '0; mPrev = '0; mTs = '0; mOvf = '0;
      sb.delete();
    end else begin
      hit  = enable && (|((mS2 & ~mPrev & rise_mask) | (~mS2 & mPrev & fall_mask)));
      word = {mS2, mTs};
      drop = 1'b0;
      if (ev_ready && sb.size() != 0) void'(sb.pop_front());
      if (hit) begin
        if (sb.size() < 2) sb.push_back(word);
        else drop = 1'b1;
      end
      if (ovf_clr) mOvf = '0;
      else if (drop && mOvf != 16'hFFFF) mOvf = mOvf + 16'd1;
      if (ts_load) mTs = ts_load_val;
      else if (enable) mTs = mTs + 48'd1;
      mPrev = mS2;
      mS2   = mS1;
      mS1   = io_in;
    end
    @(posedge clk);
    #1;
    if (chkEn) begin
      checkOutput("sbValid", 64'(ev_valid), 64'(sb.size() != 0));
      if (sb.size() != 0) checkOutput("sbData", ev_data, sb[0]);
      checkOutput("sbTs", 64'(timestamp), 64'(mTs));
      checkOutput("sbOvf", 64'(ovf_cnt), 64'(mOvf));
    end
  endtask

  initial begin
    mS1 = '0; mS2 = '0; mPrev = '0; mTs = '0; mOvf = '0;
    vecs[0] = '{16'h0000, 16'h0001, 16'h0001, 16'h0000, 1'b1, 16'h0001};
    vecs[1] = '{16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000};
    vecs[2] = '{16'h0001, 16'h0000, 16'h0000, 16'h0001, 1'b1, 16'h0000};
    vecs[3] = '{16'h0000, 16'h00F0, 16'h0010, 16'h0000, 1'b1, 16'h00F0};
    vecs[4] = '{16'h00F0, 16'h0F0F, 16'h0000, 16'h0080, 1'b1, 16'h0F0F};
    vecs[5] = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 16'h0000};
    vecs[6] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 16'h0000};
    vecs[7] = '{16'hA5A5, 16'h5A5A, 16'hFFFF, 16'hFFFF, 1'b1, 16'h5A5A};

    reset = 1'b1; enable = 1'b0; ts_load = 1'b0; ts_load_val = '0;
    ovf_clr = 1'b0; ev_ready = 1'b1;
    applyStimulus(16'h0000, 16'h0000, 16'h0000);
    tick();
    tick();
    checkOutput("rstValid", 64'(ev_valid), 64'd0);
    checkOutput("rstData", ev_data, 64'd0);
    checkOutput("rstTs", 64'(timestamp), 64'd0);
    checkOutput("rstOvf", 64'(ovf_cnt), 64'd0);
    reset = 1'b0;

    $display("[TB] timestamp load and wrap");
    enable = 1'b1; ts_load = 1'b1; ts_load_val = 48'hFFFF_FFFF_FFFF;
    tick();
    ts_load = 1'b0;
    checkOutput("tsLoad", 64'(timestamp), 64'h0000_FFFF_FFFF_FFFF);
    tick();
    checkOutput("tsWrap", 64'(timestamp), 64'd0);

    $display("[TB] edge vectors");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].fromLvl, 16'h0000, 16'h0000);
      repeat (4) tick();
      applyStimulus(vecs[i].toLvl, vecs[i].rise, vecs[i].fall);
      expTs = mTs + 48'd2;
      tick();
      checkOutput($sformatf("vec%0dEdgeN", i), 64'(ev_valid), 64'd0);
      tick();
      checkOutput($sformatf("vec%0dEdgeN1", i), 64'(ev_valid), 64'd0);
      tick();
      checkOutput($sformatf("vec%0dValid", i), 64'(ev_valid), 64'(vecs[i].expEv));
      if (vecs[i].expEv) begin
        checkOutput($sformatf("vec%0dSnap", i), 64'(ev_data[63:48]), 64'(vecs[i].expSnap));
        checkOutput($sformatf("vec%0dTs", i), 64'(ev_data[47:0]), 64'(expTs));
      end
      tick();
      checkOutput($sformatf("vec%0dSingle", i), 64'(ev_valid), 64'd0);
    end

    $display("[TB] stalled consumer, three events");
    applyStimulus(16'h0000, 16'h0000, 16'h0000);
    repeat (5) tick();
    ev_ready = 1'b0;
    rise_mask = 16'h0001;
    for (int k = 0; k < 3; k++) begin
      io_in = 16'h0001;
      tsExp[k] = mTs + 48'd2;
      repeat (4) tick();
      io_in = 16'h0000;
      repeat (4) tick();
    end
    checkOutput("stallOvf", 64'(ovf_cnt), 64'd1);
    checkOutput("stallValid", 64'(ev_valid), 64'd1);
    checkOutput("stallSnap", 64'(ev_data[63:48]), 64'h0001);
    checkOutput("stallFirstTs", 64'(ev_data[47:0]), 64'(tsExp[0]));
    ev_ready = 1'b1;
    tick();
    checkOutput("drainSecondValid", 64'(ev_valid), 64'd1);
    checkOutput("drainSecondTs", 64'(ev_data[47:0]), 64'(tsExp[1]));
    tick();
    checkOutput("drainEmpty", 64'(ev_valid), 64'd0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checkOutput("ovfClr", 64'(ovf_cnt), 64'd0);

    $display("[TB] full buffer with push and pop together");
    ev_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      io_in = 16'h0001;
      tsExp[k] = mTs + 48'd2;
      repeat (4) tick();
      io_in = 16'h0000;
      repeat (4) tick();
    end
    io_in = 16'h0001;
    tsExp[2] = mTs + 48'd2;
    tick();
    tick();
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    checkOutput("pushPopOvf", 64'(ovf_cnt), 64'd0);
    checkOutput("pushPopValid", 64'(ev_valid), 64'd1);
    checkOutput("pushPopHead", 64'(ev_data[47:0]), 64'(tsExp[1]));
    tick();
    checkOutput("stableHead", 64'(ev_data[47:0]), 64'(tsExp[1]));
    ev_ready = 1'b1;
    tick();
    checkOutput("pushPopThird", 64'(ev_data[47:0]), 64'(tsExp[2]));
    tick();
    checkOutput("pushPopEmpty", 64'(ev_valid), 64'd0);
    io_in = 16'h0000;
    repeat (4) tick();

    $display("[TB] enable gating");
    ev_ready = 1'b0;
    applyStimulus(16'h0001, 16'h0001, 16'h0001);
    tsExp[0] = mTs + 48'd2;
    repeat (4) tick();
    enable = 1'b0;
    io_in = 16'h0000;
    repeat (6) tick();
    checkOutput("disHeldValid", 64'(ev_valid), 64'd1);
    checkOutput("disHeldTs", 64'(ev_data[47:0]), 64'(tsExp[0]));
    enable = 1'b1;
    repeat (4) tick();
    checkOutput("reEnHead", 64'(ev_data[47:0]), 64'(tsExp[0]));
    ev_ready = 1'b1;
    tick();
    checkOutput("reEnNoEvent", 64'(ev_valid), 64'd0);

    $display("[TB] overflow saturation");
    ev_ready = 1'b0;
    chkEn = 1'b0;
    for (int c = 0; c < 70000 && mOvf != 16'hFFFF; c++) begin
      io_in[0] = ~io_in[0];
      tick();
    end
    chkEn = 1'b1;
    checkOutput("satReached", 64'(ovf_cnt), 64'hFFFF);
    for (int c = 0; c < 3; c++) begin
      io_in[0] = ~io_in[0];
      tick();
      checkOutput("satHold", 64'(ovf_cnt), 64'hFFFF);
    end
    ovf_clr = 1'b1;
    io_in[0] = ~io_in[0];
    tick();
    checkOutput("clrOverDrop", 64'(ovf_cnt), 64'd0);
    ovf_clr = 1'b0;
    io_in[0] = ~io_in[0];
    tick();
    checkOutput("countResume", 64'(ovf_cnt), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midRstValid", 64'(ev_valid), 64'd0);
    checkOutput("midRstOvf", 64'(ovf_cnt), 64'd0);
    checkOutput("midRstData", ev_data, 64'd0);
    checkOutput("midRstTs", 64'(timestamp), 64'd0);

    $display("[TB] high pin out of reset");
    applyStimulus(16'h0001, 16'h0001, 16'h0000);
    ev_ready = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    checkOutput("postRstEarly", 64'(ev_valid), 64'd0);
    tick();
    checkOutput("postRstValid", 64'(ev_valid), 64'd1);
    checkOutput("postRstSnap", 64'(ev_data[63:48]), 64'h0001);
    checkOutput("postRstTs", 64'(ev_data[47:0]), 64'd2);
    tick();
    checkOutput("postRstOnce", 64'(ev_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
